// File: rtl/uart_hex_entry_parser.sv
// Hex-entry parser between the UART receiver and the two-digit display.
// Define UART_HEX_ECHO_EN to build the echo FIFO back to the UART transmitter.
module uart_hex_entry_parser #(
    parameter int ECHO_DEPTH      = 4,
    parameter int ERROR_HOLD_CLKS = 12_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic [7:0] o_Display_Byte,
    output logic       o_Display_Valid,
    output logic       o_Error,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    output logic       o_Echo_Overflow
);

    localparam int ERR_W = (ERROR_HOLD_CLKS > 0) ? $clog2(ERROR_HOLD_CLKS + 1) : 1;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} t_State;

    t_State           r_State, w_Next_State;
    logic [7:0]       r_Pending, w_Next_Pending;
    logic [7:0]       r_Display_Byte;
    logic             r_Display_Valid;
    logic [ERR_W-1:0] r_Err_Cnt;
    logic             w_Commit, w_Err;
    logic             w_Is_Hex, w_Is_Cr, w_Is_Bs, w_Is_Esc, w_Is_Inv;
    logic [3:0]       w_Nib;

    // Letters carry their value in the low nibble offset by 9 ('A' = 0x41 -> 10).
    always_comb begin
        w_Is_Hex = 1'b0;
        w_Nib    = 4'h0;
        if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
            w_Is_Hex = 1'b1;
            w_Nib    = i_RX_Byte[3:0];
        end else if ((i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) ||
                     (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66)) begin
            w_Is_Hex = 1'b1;
            w_Nib    = i_RX_Byte[3:0] + 4'd9;
        end
        w_Is_Cr  = (i_RX_Byte == 8'h0D);
        w_Is_Bs  = (i_RX_Byte == 8'h08) || (i_RX_Byte == 8'h7F);
        w_Is_Esc = (i_RX_Byte == 8'h1B);
        w_Is_Inv = !(w_Is_Hex || w_Is_Cr || w_Is_Bs || w_Is_Esc);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State   <= S_EMPTY;
            r_Pending <= 8'h00;
        end else begin
            r_State   <= w_Next_State;
            r_Pending <= w_Next_Pending;
        end
    end

    always_comb begin
        w_Next_State   = r_State;
        w_Next_Pending = r_Pending;
        w_Commit       = 1'b0;
        w_Err          = 1'b0;
        if (i_RX_DV) begin
            case (r_State)
                S_EMPTY: begin
                    if (w_Is_Hex) begin
                        w_Next_State   = S_ONE;
                        w_Next_Pending = {4'h0, w_Nib};
                    end else if (w_Is_Inv) begin
                        w_Err = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_Is_Hex) begin
                        w_Next_State   = S_TWO;
                        w_Next_Pending = {r_Pending[3:0], w_Nib};
                    end else if (w_Is_Cr || w_Is_Bs || w_Is_Esc) begin
                        w_Commit       = w_Is_Cr;
                        w_Next_State   = S_EMPTY;
                        w_Next_Pending = 8'h00;
                    end else begin
                        w_Err = 1'b1;
                    end
                end
                S_TWO: begin
                    if (w_Is_Cr || w_Is_Esc) begin
                        w_Commit       = w_Is_Cr;
                        w_Next_State   = S_EMPTY;
                        w_Next_Pending = 8'h00;
                    end else if (w_Is_Bs) begin
                        w_Next_State   = S_ONE;
                        w_Next_Pending = {4'h0, r_Pending[7:4]};
                    end else begin
                        w_Err = 1'b1;
                    end
                end
                default: begin
                    w_Next_State   = S_EMPTY;
                    w_Next_Pending = 8'h00;
                end
            endcase
        end
    end

    // Display latch plus the retriggerable error hold counter.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Display_Byte  <= 8'h00;
            r_Display_Valid <= 1'b0;
            r_Err_Cnt       <= '0;
        end else begin
            if (w_Commit) begin
                r_Display_Byte  <= r_Pending;
                r_Display_Valid <= 1'b1;
            end
            if (w_Err)
                r_Err_Cnt <= ERR_W'(ERROR_HOLD_CLKS);
            else if (r_Err_Cnt != '0)
                r_Err_Cnt <= r_Err_Cnt - ERR_W'(1);
        end
    end

    assign o_Display_Byte  = r_Display_Byte;
    assign o_Display_Valid = r_Display_Valid;
    assign o_Error         = (r_Err_Cnt != '0);

`ifdef UART_HEX_ECHO_EN
    localparam int AW = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    r_Fifo [ECHO_DEPTH];
    logic [AW-1:0] r_Wr, r_Rd, w_Wr2;
    logic [CW-1:0] r_Count, w_Space;
    logic          r_Busy, r_LF_Pend, r_TX_DV, r_Ovf;
    logic [7:0]    r_TX_Byte, w_Echo_Byte;
    logic          w_Pop, w_Acc_LF, w_Acc_Echo;

    // The deferred LF and a fresh strobe may both land in one cycle; LF goes first.
    always_comb begin
        w_Echo_Byte = (w_Is_Inv || (w_Is_Hex && r_State == S_TWO)) ? 8'h3F : i_RX_Byte;
        w_Pop       = (r_Count != '0) && !r_Busy && !i_TX_Active;
        w_Space     = CW'(ECHO_DEPTH) - r_Count + CW'(w_Pop);
        w_Acc_LF    = r_LF_Pend && (w_Space != '0);
        w_Acc_Echo  = i_RX_DV && (w_Space > CW'(w_Acc_LF));
        w_Wr2       = r_Wr + AW'(w_Acc_LF);
    end

    always_ff @(posedge i_Clk) begin
        if (w_Acc_LF)
            r_Fifo[r_Wr] <= 8'h0A;
        if (w_Acc_Echo)
            r_Fifo[w_Wr2] <= w_Echo_Byte;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Wr      <= '0;
            r_Rd      <= '0;
            r_Count   <= '0;
            r_Busy    <= 1'b0;
            r_LF_Pend <= 1'b0;
            r_TX_DV   <= 1'b0;
            r_TX_Byte <= 8'h00;
            r_Ovf     <= 1'b0;
        end else begin
            r_LF_Pend <= i_RX_DV && w_Is_Cr;
            r_TX_DV   <= w_Pop;
            if (w_Pop) begin
                r_TX_Byte <= r_Fifo[r_Rd];
                r_Rd      <= r_Rd + AW'(1);
            end
            r_Wr    <= r_Wr + AW'(w_Acc_LF) + AW'(w_Acc_Echo);
            r_Count <= r_Count - CW'(w_Pop) + CW'(w_Acc_LF) + CW'(w_Acc_Echo);
            if (w_Pop)
                r_Busy <= 1'b1;
            else if (i_TX_Done)
                r_Busy <= 1'b0;
            if ((r_LF_Pend && !w_Acc_LF) || (i_RX_DV && !w_Acc_Echo))
                r_Ovf <= 1'b1;
        end
    end

    assign o_TX_DV         = r_TX_DV;
    assign o_TX_Byte       = r_TX_Byte;
    assign o_Echo_Overflow = r_Ovf;
`else
    logic w_unused;
    assign w_unused        = &{1'b0, i_TX_Active, i_TX_Done, (ECHO_DEPTH != 0)};
    assign o_TX_DV         = 1'b0;
    assign o_TX_Byte       = 8'h00;
    assign o_Echo_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_hex_entry_parser.sv
// Directed scoreboard bench for uart_hex_entry_parser (ERROR_HOLD_CLKS = 16).
// Echo checks are built in only when UART_HEX_ECHO_EN is defined.
module tb_uart_hex_entry_parser;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L, i_RX_DV, i_TX_Active, i_TX_Done;
    logic [7:0] i_RX_Byte;
    logic [7:0] o_Display_Byte, o_TX_Byte;
    logic       o_Display_Valid, o_Error, o_TX_DV, o_Echo_Overflow;

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] dispQ[$];
    logic [7:0] txQ[$];
    int         mCount = 0;
    logic       mOvf   = 1'b0;

    uart_hex_entry_parser #(.ECHO_DEPTH(4), .ERROR_HOLD_CLKS(16)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
        .o_Display_Byte(o_Display_Byte), .o_Display_Valid(o_Display_Valid),
        .o_Error(o_Error), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
        .i_TX_Active(i_TX_Active), .i_TX_Done(i_TX_Done),
        .o_Echo_Overflow(o_Echo_Overflow)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        tick();
        i_RX_DV   = 1'b0;
        i_RX_Byte = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkDisplay(input string tag);
        logic [7:0] e;
        if (dispQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $error("[TB] FAIL %s: observed commit expected none queued", tag);
        end else begin
            e = dispQ.pop_front();
            checkOutput(tag, o_Display_Byte, e);
            checkOutput({tag, "_valid"}, o_Display_Valid, 1);
        end
    endtask

    task automatic checkEchoIdle(input string tag);
        checkOutput({tag, "_txdv"}, o_TX_DV, 0);
        checkOutput({tag, "_txbyte"}, o_TX_Byte, 0);
`ifndef UART_HEX_ECHO_EN
        checkOutput({tag, "_ovf"}, o_Echo_Overflow, 0);
`endif
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_disp"}, o_Display_Byte, 0);
        checkOutput({tag, "_valid"}, o_Display_Valid, 0);
        checkOutput({tag, "_err"}, o_Error, 0);
        checkOutput({tag, "_txdv"}, o_TX_DV, 0);
        checkOutput({tag, "_txbyte"}, o_TX_Byte, 0);
        checkOutput({tag, "_ovf"}, o_Echo_Overflow, 0);
    endtask

    task automatic modelPush(input logic [7:0] b);
        if (mCount < 4) begin
            txQ.push_back(b);
            mCount++;
        end else begin
            mOvf = 1'b1;
        end
    endtask

    task automatic drainTx(input int n);
        int waited;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (o_TX_DV !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            if (o_TX_DV !== 1'b1) begin
                testsRun++;
                testsFailed++;
                $error("[TB] FAIL tx_wait: observed no o_TX_DV expected pulse %0d", k);
            end else if (txQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $error("[TB] FAIL tx_extra: observed 0x%0h expected no pulse", o_TX_Byte);
            end else begin
                checkOutput("tx_byte", o_TX_Byte, txQ.pop_front());
                if (mCount > 0) mCount--;
            end
            repeat (3) begin
                tick();
                checkOutput("tx_no_b2b", o_TX_DV, 0);
            end
            i_TX_Done = 1'b1;
            tick();
            i_TX_Done = 1'b0;
        end
    endtask

    initial begin
        i_Rst_L = 1'b0; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
        i_TX_Active = 1'b1; i_TX_Done = 1'b0;
        #1;
        repeat (3) tick();
        checkAllZero("reset");
        i_Rst_L = 1'b1;
        tick();

        // '3','c',CR -> 0x3C one cycle after CR
        dispQ.push_back(8'h3C);
        applyStimulus(8'h33);
        applyStimulus(8'h63);
        checkOutput("pre_cr_valid", o_Display_Valid, 0);
        applyStimulus(8'h0D);
        checkDisplay("disp_3c");
        checkEchoIdle("idle1");

        // '7',CR; then 'A','5',BS,'F',CR; then '1',ESC,CR does not commit
        dispQ.push_back(8'h07);
        applyStimulus(8'h37);
        applyStimulus(8'h0D);
        checkDisplay("disp_07");
        dispQ.push_back(8'hAF);
        applyStimulus(8'h41);
        applyStimulus(8'h35);
        applyStimulus(8'h08);
        applyStimulus(8'h46);
        applyStimulus(8'h0D);
        checkDisplay("disp_af");
        applyStimulus(8'h31);
        applyStimulus(8'h1B);
        applyStimulus(8'h0D);
        checkOutput("esc_no_commit", o_Display_Byte, 8'hAF);
        checkOutput("no_err_yet", o_Error, 0);

        // '5' then 'G' error, 'x' retrigger at cycle 10, state ONE kept
        applyStimulus(8'h35);
        applyStimulus(8'h47);
        checkOutput("err_set", o_Error, 1);
        repeat (9) begin
            tick();
            checkOutput("err_hold", o_Error, 1);
        end
        applyStimulus(8'h78);
        for (int i = 0; i < 15; i++) begin
            tick();
            checkOutput("err_retrig", o_Error, 1);
        end
        tick();
        checkOutput("err_clear", o_Error, 0);
        dispQ.push_back(8'h05);
        applyStimulus(8'h0D);
        checkDisplay("disp_05_kept");

        // '1','2','3',CR: third digit rejected
        dispQ.push_back(8'h12);
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        checkOutput("err_two_ok", o_Error, 0);
        applyStimulus(8'h33);
        checkOutput("err_third", o_Error, 1);
        applyStimulus(8'h0D);
        checkDisplay("disp_12");
        checkEchoIdle("idle4");

`ifdef UART_HEX_ECHO_EN
        i_TX_Active = 1'b1;
        i_Rst_L = 1'b0;
        tick();
        i_Rst_L = 1'b1;
        tick();
        modelPush(8'h31); applyStimulus(8'h31);
        modelPush(8'h32); applyStimulus(8'h32);
        modelPush(8'h3F); applyStimulus(8'h33);
        modelPush(8'h3F); applyStimulus(8'h34);
        modelPush(8'h3F); applyStimulus(8'h35);
        checkOutput("echo_ovf", o_Echo_Overflow, mOvf);
        checkOutput("echo_held", o_TX_DV, 0);
        i_TX_Active = 1'b0;
        drainTx(4);
        checkOutput("echo_q_empty", txQ.size(), 0);
        repeat (5) begin
            tick();
            checkOutput("echo_drained", o_TX_DV, 0);
        end
        checkOutput("echo_ovf_sticky", o_Echo_Overflow, 1);
        i_TX_Active = 1'b1;
        txQ.push_back(8'h1B);
        txQ.push_back(8'h62);
        txQ.push_back(8'h0D);
        txQ.push_back(8'h0A);
`else
        i_TX_Active = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h31 + 8'(i));
            i_TX_Done = 1'b1;
            tick();
            i_TX_Done = 1'b0;
            checkEchoIdle("noecho");
        end
`endif
        dispQ.push_back(8'h0B);
        applyStimulus(8'h1B);
        applyStimulus(8'h62);
        applyStimulus(8'h0D);
        checkDisplay("disp_0b");
`ifdef UART_HEX_ECHO_EN
        tick();
        i_TX_Active = 1'b0;
        drainTx(4);
        i_TX_Active = 1'b1;
`endif

        // Reset mid-entry and mid-echo, then '4','2',CR
        applyStimulus(8'h37);
        applyStimulus(8'h38);
        applyStimulus(8'h5A);
        i_TX_Active = 1'b0;
        tick();
`ifdef UART_HEX_ECHO_EN
        checkOutput("mid_echo_dv", o_TX_DV, 1);
`endif
        i_TX_Active = 1'b1;
        i_Rst_L = 1'b0;
        tick();
        checkAllZero("mid_reset");
        i_Rst_L = 1'b1;
        txQ.delete();
        i_TX_Active = 1'b0;
        repeat (4) begin
            tick();
            checkOutput("fifo_cleared", o_TX_DV, 0);
        end
        i_TX_Active = 1'b1;
        dispQ.push_back(8'h42);
        applyStimulus(8'h34);
        applyStimulus(8'h32);
        applyStimulus(8'h0D);
        checkDisplay("disp_42");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
